// File: rtl/leg_pkg.sv
// Shared constants and types for the LEG program-counter stage.
package leg_pkg;

    localparam int unsigned LEG_PC_WIDTH    = 8;
    localparam int unsigned LEG_INSTR_BYTES = 4;
    localparam int unsigned LEG_STACK_DEPTH = 8;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HALT = 1'b1
    } leg_pc_state_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned leg_sp_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned LEG_SP_WIDTH = leg_sp_width(LEG_STACK_DEPTH);

endpackage

// File: rtl/leg_ret_stack.sv
// Return-address LIFO: registered storage, combinational top-of-stack read.
module leg_ret_stack
    import leg_pkg::*;
#(
    parameter int unsigned DEPTH = LEG_STACK_DEPTH,
    parameter int unsigned WIDTH = LEG_PC_WIDTH,
    localparam int unsigned CW   = leg_sp_width(DEPTH),
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = count_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign dout   = mem_q[rd_idx];
    assign count  = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

    // Contents need no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/leg_pc_unit.sv
// Program counter, branch resolution, CALL/RET stack control and RUN/HALT FSM.
module leg_pc_unit
    import leg_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = LEG_PC_WIDTH,
    parameter int unsigned INSTR_BYTES = LEG_INSTR_BYTES,
    parameter int unsigned STACK_DEPTH = LEG_STACK_DEPTH,
    localparam int unsigned SP_WIDTH   = leg_sp_width(STACK_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                is_cond,
    input  logic                cond,
    input  logic                is_call,
    input  logic                is_ret,
    input  logic                is_halt,
    input  logic                resume,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                taken,
    output logic                halted,
    output logic                stack_err,
    output logic [SP_WIDTH-1:0] sp
);

    leg_pc_state_t     state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                taken_q, taken_d;
    logic                err_q, err_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] ret_addr;
    logic                push, pop, full, empty;
    logic                exec;

    assign pc_inc = pc_q + PC_WIDTH'(INSTR_BYTES);
    assign exec   = (state_q == PC_RUN) && !stall;

    leg_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ret_addr),
        .count (sp),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PC_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Stack faults halt the core and latch until reset.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            PC_RUN: begin
                if (!stall) begin
                    if (is_halt) begin
                        state_d = PC_HALT;
                    end else if (is_ret) begin
                        if (empty) begin
                            err_d   = 1'b1;
                            state_d = PC_HALT;
                        end
                    end else if (is_call && full) begin
                        err_d   = 1'b1;
                        state_d = PC_HALT;
                    end
                end
            end
            PC_HALT: begin
                if (resume && !err_q) begin
                    state_d = PC_RUN;
                end
            end
            default: state_d = PC_RUN;
        endcase
    end

    // Priority mux: halt > ret > call > taken cond > sequential.
    always_comb begin
        pc_d    = pc_q;
        taken_d = taken_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (exec) begin
            taken_d = 1'b0;
            if (is_halt) begin
                pc_d = pc_q;
            end else if (is_ret) begin
                if (!empty) begin
                    pop     = 1'b1;
                    pc_d    = ret_addr;
                    taken_d = 1'b1;
                end
            end else if (is_call) begin
                if (!full) begin
                    push    = 1'b1;
                    pc_d    = target;
                    taken_d = 1'b1;
                end
            end else if (is_cond && cond) begin
                pc_d    = target;
                taken_d = 1'b1;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    assign pc        = pc_q;
    assign taken     = taken_q;
    assign halted    = (state_q == PC_HALT);
    assign stack_err = err_q;

endmodule

// File: tb/tb_leg_pc_unit.sv
// Directed self-checking bench for leg_pc_unit.
module tb_leg_pc_unit;

    logic       clk;
    logic       rst;
    logic       stall, is_cond, cond, is_call, is_ret, is_halt, resume;
    logic [7:0] target;
    logic [7:0] pc;
    logic       taken, halted, stack_err;
    logic [3:0] sp;

    int checks;
    int failures;

    leg_pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .is_cond   (is_cond),
        .cond      (cond),
        .is_call   (is_call),
        .is_ret    (is_ret),
        .is_halt   (is_halt),
        .resume    (resume),
        .target    (target),
        .pc        (pc),
        .taken     (taken),
        .halted    (halted),
        .stack_err (stack_err),
        .sp        (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_flags();
        stall = 0; is_cond = 0; cond = 0; is_call = 0;
        is_ret = 0; is_halt = 0; resume = 0; target = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_flags();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 8'h00 || sp !== 4'd0 || taken !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%h sp=%0d taken=%b halted=%b err=%b, want 00 0 0 0 0",
                     pc, sp, taken, halted, stack_err);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (pc !== 8'(4 * i) || taken !== 1'b0 || sp !== 4'd0) begin
                failures++;
                $display("FAIL free_run[%0d]: pc=%h taken=%b sp=%0d, want %h 0 0", i, pc, taken, sp, 8'(4 * i));
            end
        end
    endtask

    task automatic test_cond();
        do_reset();
        step(); step();
        is_cond = 1; cond = 1; target = 8'h40;
        step();
        checks++;
        if (pc !== 8'h40 || taken !== 1'b1) begin
            failures++;
            $display("FAIL cond_taken: pc=%h taken=%b, want 40 1", pc, taken);
        end
        do_reset();
        step(); step();
        is_cond = 1; cond = 0; target = 8'h40;
        step();
        checks++;
        if (pc !== 8'h0c || taken !== 1'b0) begin
            failures++;
            $display("FAIL cond_not_taken: pc=%h taken=%b, want 0c 0", pc, taken);
        end
        clear_flags();
    endtask

    task automatic test_call_ret();
        do_reset();
        repeat (4) step();
        is_call = 1; target = 8'h80;
        step();
        checks++;
        if (pc !== 8'h80 || sp !== 4'd1 || taken !== 1'b1) begin
            failures++;
            $display("FAIL call: pc=%h sp=%0d taken=%b, want 80 1 1", pc, sp, taken);
        end
        clear_flags();
        is_ret = 1;
        step();
        checks++;
        if (pc !== 8'h14 || sp !== 4'd0 || taken !== 1'b1) begin
            failures++;
            $display("FAIL ret: pc=%h sp=%0d taken=%b, want 14 0 1", pc, sp, taken);
        end
        clear_flags();
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (4) step();
        is_call = 1; target = 8'h30;
        step();
        target = 8'h60;
        step();
        checks++;
        if (pc !== 8'h60 || sp !== 4'd2) begin
            failures++;
            $display("FAIL nested_call: pc=%h sp=%0d, want 60 2", pc, sp);
        end
        clear_flags();
        is_ret = 1;
        step();
        checks++;
        if (pc !== 8'h34 || sp !== 4'd1) begin
            failures++;
            $display("FAIL ret_inner: pc=%h sp=%0d, want 34 1", pc, sp);
        end
        step();
        checks++;
        if (pc !== 8'h14 || sp !== 4'd0 || taken !== 1'b1) begin
            failures++;
            $display("FAIL ret_outer: pc=%h sp=%0d taken=%b, want 14 0 1", pc, sp, taken);
        end
        clear_flags();
    endtask

    task automatic test_overflow();
        do_reset();
        is_call = 1;
        for (int i = 0; i < 8; i++) begin
            target = 8'(8'h80 + 8 * i);
            step();
        end
        checks++;
        if (pc !== 8'hb8 || sp !== 4'd8 || halted !== 1'b0) begin
            failures++;
            $display("FAIL fill_stack: pc=%h sp=%0d halted=%b, want b8 8 0", pc, sp, halted);
        end
        target = 8'hf0;
        step();
        checks++;
        if (pc !== 8'hb8 || sp !== 4'd8 || stack_err !== 1'b1 || halted !== 1'b1 || taken !== 1'b0) begin
            failures++;
            $display("FAIL overflow: pc=%h sp=%0d err=%b halted=%b taken=%b, want b8 8 1 1 0",
                     pc, sp, stack_err, halted, taken);
        end
        clear_flags();
        resume = 1;
        step(); step();
        checks++;
        if (halted !== 1'b1 || pc !== 8'hb8 || stack_err !== 1'b1) begin
            failures++;
            $display("FAIL resume_on_fault: halted=%b pc=%h err=%b, want 1 b8 1", halted, pc, stack_err);
        end
        do_reset();
        checks++;
        if (pc !== 8'h00 || sp !== 4'd0 || stack_err !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL fault_reset: pc=%h sp=%0d err=%b halted=%b, want 00 0 0 0", pc, sp, stack_err, halted);
        end
    endtask

    task automatic test_underflow_halt();
        do_reset();
        is_ret = 1;
        step();
        checks++;
        if (stack_err !== 1'b1 || halted !== 1'b1 || pc !== 8'h00 || sp !== 4'd0) begin
            failures++;
            $display("FAIL underflow: err=%b halted=%b pc=%h sp=%0d, want 1 1 00 0", stack_err, halted, pc, sp);
        end
        do_reset();
        step();
        is_halt = 1;
        step();
        checks++;
        if (halted !== 1'b1 || pc !== 8'h04 || taken !== 1'b0 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL halt: halted=%b pc=%h taken=%b err=%b, want 1 04 0 0", halted, pc, taken, stack_err);
        end
        for (int i = 0; i < 5; i++) begin
            stall = 1'(i % 2); is_call = 1; is_cond = 1; cond = 1; is_ret = 1'(i % 3 == 0);
            target = 8'h99;
            step();
            checks++;
            if (pc !== 8'h04 || sp !== 4'd0 || halted !== 1'b1) begin
                failures++;
                $display("FAIL halt_frozen[%0d]: pc=%h sp=%0d halted=%b, want 04 0 1", i, pc, sp, halted);
            end
        end
        clear_flags();
        resume = 1;
        step();
        checks++;
        if (halted !== 1'b0 || pc !== 8'h04) begin
            failures++;
            $display("FAIL resume: halted=%b pc=%h, want 0 04", halted, pc);
        end
        resume = 0;
        step();
        checks++;
        if (pc !== 8'h08) begin
            failures++;
            $display("FAIL post_resume: pc=%h, want 08", pc);
        end
    endtask

    task automatic test_wrap_stall();
        do_reset();
        is_cond = 1; cond = 1; target = 8'hfc;
        step();
        clear_flags();
        step();
        checks++;
        if (pc !== 8'h00) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h, want 00", pc);
        end
        is_cond = 1; cond = 1; target = 8'hfc;
        step();
        clear_flags();
        is_call = 1; target = 8'h10;
        step();
        clear_flags();
        is_ret = 1;
        step();
        checks++;
        if (pc !== 8'h00 || sp !== 4'd0 || taken !== 1'b1) begin
            failures++;
            $display("FAIL ret_addr_wrap: pc=%h sp=%0d taken=%b, want 00 0 1", pc, sp, taken);
        end
        clear_flags();
        is_cond = 1; cond = 1; target = 8'h40;
        step();
        clear_flags();
        stall = 1; is_call = 1; target = 8'h80;
        step();
        checks++;
        if (pc !== 8'h40 || sp !== 4'd0 || taken !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: pc=%h sp=%0d taken=%b, want 40 0 1", pc, sp, taken);
        end
        clear_flags();
        step();
        checks++;
        if (pc !== 8'h44 || taken !== 1'b0) begin
            failures++;
            $display("FAIL after_stall: pc=%h taken=%b, want 44 0", pc, taken);
        end
    endtask

    task automatic test_priority();
        do_reset();
        is_call = 1; is_cond = 1; cond = 1; target = 8'h50;
        step();
        checks++;
        if (pc !== 8'h50 || sp !== 4'd1) begin
            failures++;
            $display("FAIL call_over_cond: pc=%h sp=%0d, want 50 1", pc, sp);
        end
        is_ret = 1; target = 8'h70;
        step();
        checks++;
        if (pc !== 8'h04 || sp !== 4'd0) begin
            failures++;
            $display("FAIL ret_over_call: pc=%h sp=%0d, want 04 0", pc, sp);
        end
        is_halt = 1;
        step();
        checks++;
        if (pc !== 8'h04 || sp !== 4'd0 || halted !== 1'b1 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL halt_over_all: pc=%h sp=%0d halted=%b err=%b, want 04 0 1 0", pc, sp, halted, stack_err);
        end
        clear_flags();
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (5) step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (pc !== 8'h00 || halted !== 1'b0 || taken !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pc=%h halted=%b taken=%b, want 00 0 0", pc, halted, taken);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (pc !== 8'h04) begin
            failures++;
            $display("FAIL after_async_reset: pc=%h, want 04", pc);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clear_flags();
        test_reset();
        test_cond();
        test_call_ret();
        test_back_to_back();
        test_overflow();
        test_underflow_halt();
        test_wrap_stall();
        test_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leg_pc_unit.md
Name: leg_pc_unit

Overview:
- Program-counter and branch-resolution stage of the LEG core.
- Sits directly downstream of the condition evaluator. It consumes the 1-bit condition result and the decoded control-flow flags, and produces the next instruction address for fetch.
- Adds a small hardware return stack for CALL/RET and a RUN/HALT state machine with fault handling.

Parameters:
- PC_WIDTH, 8, width of program counter and jump target in bits.
- INSTR_BYTES, 4, bytes per instruction; the sequential PC increment.
- STACK_DEPTH, 8, number of return-address entries; must be a power of two, at least 2.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- stall  input  1  hold all state this cycle; ignored in HALT.
- is_cond  input  1  current instruction is a conditional jump.
- cond  input  1  condition result from the condition evaluator.
- is_call  input  1  current instruction is an unconditional CALL.
- is_ret  input  1  current instruction is RET.
- is_halt  input  1  current instruction is HALT.
- resume  input  1  request HALT to RUN transition.
- target  input  PC_WIDTH  jump/call destination; immediate byte of the instruction.
- pc  output  PC_WIDTH  current fetch address (registered).
- taken  output  1  registered; 1 if the last executed instruction redirected flow.
- halted  output  1  registered; 1 while in HALT.
- stack_err  output  1  sticky; set on return-stack overflow or underflow.
- sp  output  log2(STACK_DEPTH)+1  current return-stack occupancy, range 0..STACK_DEPTH.

Behaviour:
- Reset (rst=0, async): pc=0, sp=0, taken=0, halted=0, stack_err=0, state=RUN. Stack contents are don't-care. Reset mid-operation aborts any update that cycle.
- States: RUN, HALT. halted = (state==HALT).
- RUN with stall=1: pc, sp, stack, taken and state all hold.
- RUN with stall=0: exactly one action per cycle, first match in this priority order:
  1. is_halt: state→HALT; pc holds; taken=0.
  2. is_ret with sp==0: stack_err=1, state→HALT, pc holds, taken=0.
  3. is_ret with sp>0: pc←stack[sp-1], sp←sp-1, taken=1.
  4. is_call with sp==STACK_DEPTH: stack_err=1, state→HALT, pc holds, taken=0.
  5. is_call with sp<STACK_DEPTH: stack[sp]←pc+INSTR_BYTES, sp←sp+1, pc←target, taken=1.
  6. is_cond and cond: pc←target, taken=1.
  7. Otherwise (including is_cond with cond=0): pc←pc+INSTR_BYTES, taken=0.
- Arithmetic: all PC sums are modulo 2^PC_WIDTH. Example: 252+4 gives 0. A pushed return address wraps the same way.
- target is used unmasked; no alignment check.
- Single-cycle latency: flags presented in cycle n take effect on pc at the edge ending cycle n.
- HALT state:
  - pc, sp, stack and taken hold; stall and all instruction flags are ignored.
  - resume=1 with stack_err=0: state→RUN, pc unchanged.
  - resume with stack_err=1 is ignored; only reset clears a fault.
- stack_err, once set, clears only on reset.
- Simultaneous flags resolve strictly by the priority order above. Example: is_call and is_cond both high executes CALL only.

Decomposition:
- Package leg_pkg holds:
  - constants LEG_PC_WIDTH=8 and LEG_INSTR_BYTES=4;
  - enum leg_pc_state_t {PC_RUN, PC_HALT};
  - a localparam for the stack-pointer width function.
- Sub-module leg_ret_stack: a STACK_DEPTH×PC_WIDTH LIFO.
  - Ports: clk, rst, push, pop, din, dout, count, full, empty.
  - Registered storage, combinational dout = top entry.
- leg_pc_unit owns the FSM, the priority mux and the pc/taken registers, and gates push/pop by state and stall.

Test Plan:
- Reset then 3 free cycles with no flags → pc 0,4,8,12; taken=0; sp=0.
- pc=8, is_cond=1, cond=1, target=0x40 → next pc=0x40, taken=1. Repeat with cond=0 → pc=12, taken=0.
- pc=0x10, is_call, target=0x80 → pc=0x80, sp=1. Then is_ret → pc=0x14, sp=0, taken=1.
- Nine consecutive CALLs with STACK_DEPTH=8:
  - 9th → stack_err=1, halted=1, sp=8, pc held.
  - resume → still halted.
  - rst pulse → all cleared.
- is_ret at sp=0 → stack_err=1, halted=1. Separately: is_halt, then 5 cycles of flags → pc frozen; resume → RUN, pc continues +4.
- pc=252, no flags → pc=0. stall=1 with is_call → no change to pc/sp. Async rst asserted mid-cycle → pc=0 immediately, without waiting for a clock edge.
